dct8_pipe: RTL and testbench

- Parametrised 8-point fixed-point forward DCT (Loeffler butterfly), 5-stage pipeline with valid/ready handshake and output saturation.
- Successor to the fixed 32-bit free-running butterfly.
- Sits between the block-fetch/level-shift stage and the quantiser. Instantiated twice, for the row pass and the column pass.

---
 rtl/dct8_pipe.sv | 191 +++++++++++++++++++
 tb/tb_dct8_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dct8_pipe
// Brief    : 8-point Loeffler forward DCT, 5-stage stalling pipeline with
//            valid/ready handshake and saturated outputs. Optional macro
//            DCT8_ROUND_EN selects round-half-up instead of floor.
// Revision : 1.0
// ============================================================================
module dct8_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int COEF_FRAC  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] in_data_i [8],
    input  logic                         in_last_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [OUT_WIDTH-1:0]  out_data_o [8],
    output logic                         out_last_o,
    output logic                         out_sat_o
);

    localparam int PW = ACC_WIDTH + 18;
`ifdef DCT8_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic signed [PW-1:0]        prod_t;

    // Constants are given in Q16; rescale them to COEF_FRAC fractional bits.
    function automatic prod_t qcoef(input int unsigned v);
        prod_t r;
        r = prod_t'(v);
        if (COEF_FRAC >= 16) r = r <<< (COEF_FRAC - 16);
        else                 r = r >>> (16 - COEF_FRAC);
        return r;
    endfunction

    localparam prod_t K12785 = qcoef(12785);
    localparam prod_t K25079 = qcoef(25079);
    localparam prod_t K36409 = qcoef(36409);
    localparam prod_t K46340 = qcoef(46340);
    localparam prod_t K54491 = qcoef(54491);
    localparam prod_t K60547 = qcoef(60547);
    localparam prod_t K64276 = qcoef(64276);

    localparam acc_t OMAX = acc_t'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam acc_t OMIN = acc_t'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    function automatic acc_t mult(input acc_t x, input prod_t c);
        prod_t xe;
        prod_t p;
        xe = prod_t'(x);
        p  = xe * c;
        if (ROUND) p = p + (prod_t'(1) <<< (COEF_FRAC - 1));
        p = p >>> COEF_FRAC;
        return p[ACC_WIDTH-1:0];
    endfunction

    acc_t s1_q [8];
    acc_t s1_d [8];
    acc_t s2_q [8];
    acc_t s2_d [8];
    acc_t s3_q [8];
    acc_t s3_d [8];
    acc_t s4_q [8];
    acc_t s4_d [8];
    logic signed [OUT_WIDTH-1:0] y_q [8];
    logic signed [OUT_WIDTH-1:0] y_d [8];
    logic [4:0] vld_q;
    logic [4:0] lst_q;
    logic       sat_q;
    logic       sat_d;
    logic       adv;

    acc_t xe   [8];
    acc_t ord  [8];
    acc_t half;
    acc_t ma;
    acc_t mb;

    assign adv = !vld_q[4] || out_ready_i;

    always_comb begin
        for (int i = 0; i < 8; i++) xe[i] = acc_t'(in_data_i[i]);
        s1_d[0] = xe[0] + xe[7];
        s1_d[1] = xe[1] + xe[6];
        s1_d[2] = xe[2] + xe[5];
        s1_d[3] = xe[3] + xe[4];
        s1_d[4] = xe[3] - xe[4];
        s1_d[5] = xe[2] - xe[5];
        s1_d[6] = xe[1] - xe[6];
        s1_d[7] = xe[0] - xe[7];

        ma = mult(s1_q[6], K46340);
        mb = mult(s1_q[5], K46340);
        s2_d[0] = s1_q[0] + s1_q[3];
        s2_d[1] = s1_q[1] + s1_q[2];
        s2_d[2] = s1_q[1] - s1_q[2];
        s2_d[3] = s1_q[0] - s1_q[3];
        s2_d[4] = s1_q[4];
        s2_d[5] = ma - mb;
        s2_d[6] = ma + mb;
        s2_d[7] = s1_q[7];

        s3_d[0] = mult(s2_q[0], K46340) + mult(s2_q[1], K46340);
        s3_d[1] = mult(s2_q[0], K46340) - mult(s2_q[1], K46340);
        s3_d[2] = mult(s2_q[2], K25079) + mult(s2_q[3], K60547);
        s3_d[3] = mult(s2_q[3], K25079) - mult(s2_q[2], K60547);
        s3_d[4] = s2_q[4] + s2_q[5];
        s3_d[5] = s2_q[4] - s2_q[5];
        s3_d[6] = s2_q[7] - s2_q[6];
        s3_d[7] = s2_q[6] + s2_q[7];

        s4_d[0] = s3_q[0];
        s4_d[1] = s3_q[1];
        s4_d[2] = s3_q[2];
        s4_d[3] = s3_q[3];
        s4_d[4] = mult(s3_q[4], K12785) + mult(s3_q[7], K64276);
        s4_d[5] = mult(s3_q[5], K54491) + mult(s3_q[6], K36409);
        s4_d[6] = mult(s3_q[6], K54491) - mult(s3_q[5], K36409);
        s4_d[7] = mult(s3_q[7], K12785) - mult(s3_q[4], K64276);

        // Loeffler output permutation back to natural coefficient order.
        ord[0] = s4_q[0];
        ord[1] = s4_q[4];
        ord[2] = s4_q[2];
        ord[3] = s4_q[6];
        ord[4] = s4_q[1];
        ord[5] = s4_q[5];
        ord[6] = s4_q[3];
        ord[7] = s4_q[7];

        sat_d = 1'b0;
        half  = '0;
        for (int k = 0; k < 8; k++) begin
            half = (ord[k] + acc_t'(ROUND)) >>> 1;
            if (half > OMAX) begin
                y_d[k] = OMAX[OUT_WIDTH-1:0];
                sat_d  = 1'b1;
            end else if (half < OMIN) begin
                y_d[k] = OMIN[OUT_WIDTH-1:0];
                sat_d  = 1'b1;
            end else begin
                y_d[k] = half[OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            lst_q <= '0;
            sat_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
                s3_q[i] <= '0;
                s4_q[i] <= '0;
                y_q[i]  <= '0;
            end
        end else if (adv) begin
            vld_q <= {vld_q[3:0], in_valid_i};
            lst_q <= {lst_q[3:0], in_valid_i & in_last_i};
            sat_q <= sat_d;
            for (int i = 0; i < 8; i++) begin
                s1_q[i] <= s1_d[i];
                s2_q[i] <= s2_d[i];
                s3_q[i] <= s3_d[i];
                s4_q[i] <= s4_d[i];
                y_q[i]  <= y_d[i];
            end
        end
    end

    assign in_ready_o  = adv;
    assign out_valid_o = vld_q[4];
    assign out_last_o  = lst_q[4];
    assign out_sat_o   = sat_q;
    assign out_data_o  = y_q;

endmodule
`default_nettype wire

// File: tb/tb_dct8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct8_pipe
// Brief    : Directed and randomized bench for dct8_pipe with a behavioural
//            DCT reference model and scoreboard.
// Revision : 1.0
// ============================================================================
module tb_dct8_pipe;

    typedef logic [0:7][15:0] vec_t;
    typedef struct packed {
        vec_t y;
        logic sat;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic in_last;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic out_sat;
    logic signed [15:0] in_data  [8];
    logic signed [15:0] out_data [8];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dct8_pipe #(
        .DATA_WIDTH (16),
        .ACC_WIDTH  (32),
        .OUT_WIDTH  (16),
        .COEF_FRAC  (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_sat_o   (out_sat)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------
    function automatic longint w32(input longint v);
        return longint'(int'(v));
    endfunction

    function automatic longint m(input longint x, input longint c);
        longint p;
        p = x * c;
`ifdef DCT8_ROUND_EN
        p = p + 32768;
`endif
        return w32(p >>> 16);
    endfunction

    function automatic exp_t ref_dct(input vec_t xv, input logic last);
        longint x [8];
        longint a [8];
        longint b [8];
        longint c [8];
        longint d [8];
        longint yv;
        int     perm [8];
        exp_t   r;
        perm = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int i = 0; i < 8; i++) x[i] = longint'($signed(xv[i]));
        a[0] = w32(x[0] + x[7]); a[1] = w32(x[1] + x[6]);
        a[2] = w32(x[2] + x[5]); a[3] = w32(x[3] + x[4]);
        a[4] = w32(x[3] - x[4]); a[5] = w32(x[2] - x[5]);
        a[6] = w32(x[1] - x[6]); a[7] = w32(x[0] - x[7]);
        b[0] = w32(a[0] + a[3]); b[1] = w32(a[1] + a[2]);
        b[2] = w32(a[1] - a[2]); b[3] = w32(a[0] - a[3]);
        b[4] = a[4];             b[7] = a[7];
        b[5] = w32(m(a[6], 46340) - m(a[5], 46340));
        b[6] = w32(m(a[6], 46340) + m(a[5], 46340));
        c[0] = w32(m(b[0], 46340) + m(b[1], 46340));
        c[1] = w32(m(b[0], 46340) - m(b[1], 46340));
        c[2] = w32(m(b[2], 25079) + m(b[3], 60547));
        c[3] = w32(m(b[3], 25079) - m(b[2], 60547));
        c[4] = w32(b[4] + b[5]); c[5] = w32(b[4] - b[5]);
        c[6] = w32(b[7] - b[6]); c[7] = w32(b[6] + b[7]);
        d[0] = c[0]; d[1] = c[1]; d[2] = c[2]; d[3] = c[3];
        d[4] = w32(m(c[4], 12785) + m(c[7], 64276));
        d[5] = w32(m(c[5], 54491) + m(c[6], 36409));
        d[6] = w32(m(c[6], 54491) - m(c[5], 36409));
        d[7] = w32(m(c[7], 12785) - m(c[4], 64276));
        r.sat  = 1'b0;
        r.last = last;
        for (int k = 0; k < 8; k++) begin
`ifdef DCT8_ROUND_EN
            yv = w32(d[perm[k]] + 1) >>> 1;
`else
            yv = d[perm[k]] >>> 1;
`endif
            if (yv > 32767)       begin yv = 32767;  r.sat = 1'b1; end
            else if (yv < -32768) begin yv = -32768; r.sat = 1'b1; end
            r.y[k] = 16'(yv);
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ------------------------------------
    function automatic vec_t mk8(input int v0, input int v1, input int v2, input int v3,
                                 input int v4, input int v5, input int v6, input int v7);
        vec_t v;
        v[0] = 16'(v0); v[1] = 16'(v1); v[2] = 16'(v2); v[3] = 16'(v3);
        v[4] = 16'(v4); v[5] = 16'(v5); v[6] = 16'(v6); v[7] = 16'(v7);
        return v;
    endfunction

    function automatic vec_t rand_vec(input bit full);
        vec_t v;
        for (int i = 0; i < 8; i++)
            v[i] = full ? 16'($urandom_range(0, 65535))
                        : 16'(int'($urandom_range(0, 4000)) - 2000);
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        for (int i = 0; i < 8; i++) in_data[i] = $signed(v[i]);
    endtask

    task automatic directed(input string tag, input vec_t xv, input vec_t ev, input logic es);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        set_in(xv);
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        lat = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s_y%0d", tag, k), out_data[k], $signed(ev[k]));
        check({tag, "_sat"}, out_sat, es);
        check({tag, "_last"}, out_last, 0);
        @(posedge clk); #1;
    endtask

    // mode 0: ready pattern 1,0,0 repeating; mode 1: random valid and ready
    task automatic stream(input string tag, input int nvec, input int mode, input bit full);
        exp_t q [$];
        exp_t e;
        vec_t cur;
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        bit   have = 0;
        cur = '0;
        while (got < nvec && cyc < 2000) begin
            if (!have && sent < nvec) begin
                cur  = rand_vec(full);
                have = 1;
            end
            in_valid  = have && (mode == 0 || $urandom_range(0, 3) != 0);
            in_last   = (sent == nvec - 1);
            set_in(cur);
            out_ready = (mode == 0) ? (cyc % 3 == 0) : ($urandom_range(0, 1) == 1);
            #1;
            check({tag, "_in_ready"}, in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({tag, "_unexpected_out"}, out_valid, 0);
                end else begin
                    e = q.pop_front();
                    for (int k = 0; k < 8; k++)
                        check($sformatf("%s_v%0d_y%0d", tag, got, k), out_data[k], $signed(e.y[k]));
                    check($sformatf("%s_v%0d_sat", tag, got), out_sat, e.sat);
                    check($sformatf("%s_v%0d_last", tag, got), out_last, e.last);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_dct(cur, in_last));
                sent++;
                have = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_outputs_received"}, got, nvec);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        set_in('0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_sat", out_sat, 0);
        for (int k = 0; k < 8; k++) check($sformatf("rst_y%0d", k), out_data[k], 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

`ifdef DCT8_ROUND_EN
        directed("dc100", mk8(100, 100, 100, 100, 100, 100, 100, 100),
                 mk8(283, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        directed("impulse", mk8(64, 0, 0, 0, 0, 0, 0, 0),
                 mk8(23, 32, 30, 27, 23, 18, 12, 6), 1'b0);
`else
        directed("dc100", mk8(100, 100, 100, 100, 100, 100, 100, 100),
                 mk8(282, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        directed("impulse", mk8(64, 0, 0, 0, 0, 0, 0, 0),
                 mk8(22, 31, 29, 26, 22, 17, 12, 6), 1'b0);
`endif
        directed("dcm100", mk8(-100, -100, -100, -100, -100, -100, -100, -100),
                 mk8(-283, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        directed("dcmax", mk8(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767),
                 mk8(32767, 0, 0, 0, 0, 0, 0, 0), 1'b1);

        stream("bp", 8, 0, 1'b0);
        stream("rnd", 40, 1, 1'b1);

        // Reset with three vectors in flight: nothing may emerge afterwards.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_in(rand_vec(1'b1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_no_stale%0d", i), out_valid, 0);
        end
`ifdef DCT8_ROUND_EN
        directed("post_midrst", mk8(64, 0, 0, 0, 0, 0, 0, 0),
                 mk8(23, 32, 30, 27, 23, 18, 12, 6), 1'b0);
`else
        directed("post_midrst", mk8(64, 0, 0, 0, 0, 0, 0, 0),
                 mk8(22, 31, 29, 26, 22, 17, 12, 6), 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
